multi_pulse_gen: RTL and testbench
==================================

# multi_pulse_gen

Parametrised, multi-channel successor to the single-shot pulse generator. Each of `CHANNELS` independent channels emits a programmable burst of pulses (start delay, pulse width, inter-pulse gap, repeat count) in response to a per-channel start strobe. The block sits between the control/sequencer logic and the output drivers, and replaces the fixed compile-time delay and width constants with runtime configuration latched at start.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent pulse channels.
- `CNT_W`, 16: width of the delay, width and gap counters.
- `REP_W`, 8: width of the repeat count.
- `RESET_DELAY`, 10: clocks after reset release before `ready` asserts (≥1).

Ports (reset is asynchronous and active-low, named `reset`; the clock is `clk`):
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous reset, active-low.
- `start`  in  CHANNELS  per-channel start strobe, sampled each edge.
- `abort`  in  CHANNELS  per-channel synchronous abort.
- `cfg_delay`  in  CNT_W  cycles from start to first pulse rise; shared, latched at start.
- `cfg_width`  in  CNT_W  pulse high time in cycles; latched at start.
- `cfg_gap`  in  CNT_W  low time between pulses in cycles; latched at start.
- `cfg_repeat`  in  REP_W  additional pulses after the first (total = repeat+1); latched at start.
- `ready`  out  1  high once the reset delay has elapsed.
- `busy`  out  CHANNELS  channel not in IDLE.
- `pulse_out`  out  CHANNELS  pulse outputs, registered.
- `done`  out  CHANNELS  one-cycle strobe on normal burst completion.

## Operation
- Reset value of all outputs is 0. Reset is asserted mid-operation: all outputs go 0 immediately, all channels return to IDLE, and the reset-delay counter restarts.
- Per-channel FSM: IDLE → DELAY → ACTIVE → (GAP → ACTIVE)* → IDLE.
- IDLE: when `ready` is high, `start[i]` is high and `abort[i]` is low, latch the cfg values and go to DELAY. Starts while `!ready` or while `busy[i]` are ignored (no queueing).
- Zero clamp: the effective value of delay, width and gap is max(value,1). `cfg_repeat=0` produces one pulse.
- DELAY: count D cycles, then go to ACTIVE. ACTIVE: `pulse_out` high for W cycles. If pulses remain, go to GAP, hold low for G cycles, then go to ACTIVE. Otherwise go to IDLE and pulse `done`.
- Repeat counting wraps never. The remaining count is decremented per completed pulse and saturates at 0.
- Abort: `abort[i]` high in any state → next edge is IDLE with `pulse_out[i]`=0 and no `done`. Abort beats start in the same cycle. Abort in IDLE has no effect.
- Channels share the cfg bus. Simultaneous starts on several channels each latch the same cfg values.
- `busy[i]` is high from the edge after an accepted start through the edge at which the channel returns to IDLE.

## Timing
- `ready`: rises at the RESET_DELAY-th rising edge after `reset` deasserts.
- Start sampled at edge E0 → `busy` high after E0, and `pulse_out` rises at edge E0+D.
- `pulse_out` is high for exactly W clocks and falls at E0+D+W. The next rise is at E0+D+W+G.
- Last pulse falls at edge F → `done` high for the cycle following F (asserted at F, deasserted at F+1), and `busy` falls at F.
- A new start is accepted on the cycle `busy` is low, so back-to-back bursts are possible with `start` at F.
- Abort sampled at edge A → `pulse_out`, `busy` = 0 after A.

## Configuration
- Macro `PULSE_GEN_CONTINUOUS_EN`.
- Defined: `cfg_repeat` all-ones means continuous mode. Pulses repeat indefinitely with period W+G until abort or reset, and `done` never fires.
- Undefined: all-ones is an ordinary count (2^REP_W pulses). No continuous logic is synthesised.

## Test plan
- Reset release, RESET_DELAY=10 → `ready` rises exactly 10 clocks after release. A start at clock 5 is ignored (`busy` stays 0).
- delay=3, width=4, gap=2, repeat=2, start at E0 → rises at E0+3, E0+9, E0+15, each high 4 clocks. `done` is asserted at E0+19, and `busy` falls at E0+19.
- delay=0, width=0, gap=0, repeat=1 → clamp to 1: rises at E0+1 and E0+3, each 1 clock wide. One `done`.
- Ch0 mid-ACTIVE with abort[0]=1, ch1 running → ch0 `pulse_out`/`busy` low next edge with no `done`. Ch1 timing is unaffected. Start+abort in the same cycle → not accepted.
- Reset asserted mid-GAP on all channels → outputs 0 asynchronously, and `ready` rises RESET_DELAY clocks after re-release. Restart behaves per scenario 2.
- With `PULSE_GEN_CONTINUOUS_EN`, repeat=8'hFF, width=2, gap=3 → ≥20 pulses of period 5 with no `done`. Abort stops the pulses. Without the macro, exactly 256 pulses followed by `done`.

Source files
------------

// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen: per-channel programmable pulse bursts (delay, width, gap, repeat) latched at start.
// Define PULSE_GEN_CONTINUOUS_EN to make cfg_repeat all-ones mean "repeat until abort".
module multi_pulse_gen #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int REP_W       = 8,
  parameter int RESET_DELAY = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] abort,
  input  logic [CNT_W-1:0]    cfg_delay,
  input  logic [CNT_W-1:0]    cfg_width,
  input  logic [CNT_W-1:0]    cfg_gap,
  input  logic [REP_W-1:0]    cfg_repeat,
  output logic                ready,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] done
);
  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, GAP} state_t;
  localparam int RC_W = $clog2(RESET_DELAY + 1);
  logic [RC_W-1:0] rcnt;
  logic [CNT_W-1:0] d_eff, w_eff, g_eff;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rcnt  <= '0;
      ready <= 1'b0;
    end else if (!ready) begin
      rcnt  <= rcnt + RC_W'(1);
      ready <= rcnt == RC_W'(RESET_DELAY - 1);
    end
  always_comb begin
    d_eff = cfg_delay == '0 ? CNT_W'(1) : cfg_delay;
    w_eff = cfg_width == '0 ? CNT_W'(1) : cfg_width;
    g_eff = cfg_gap   == '0 ? CNT_W'(1) : cfg_gap;
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt, w, g;
    logic [REP_W-1:0] rem;
    logic             p, d, go, last;
    assign go = ready && start[i] && !abort[i];
`ifdef PULSE_GEN_CONTINUOUS_EN
    logic cont;
    always_ff @(posedge clk or negedge reset)
      if (!reset) cont <= 1'b0;
      else if (state == IDLE && go) cont <= &cfg_repeat;
    assign last = !cont && rem == '0;
`else
    assign last = rem == '0;
`endif
    // cnt always holds the cycles left in the current phase, so every phase ends at cnt == 1
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        state <= IDLE;
        cnt   <= '0;
        w     <= '0;
        g     <= '0;
        rem   <= '0;
        p     <= 1'b0;
        d     <= 1'b0;
      end else begin
        d <= 1'b0;
        if (state != IDLE && abort[i]) begin
          state <= IDLE;
          p     <= 1'b0;
        end else
          case (state)
            IDLE:
              if (go) begin
                state <= DELAY;
                cnt   <= d_eff;
                w     <= w_eff;
                g     <= g_eff;
                rem   <= cfg_repeat;
              end
            DELAY:
              if (cnt == CNT_W'(1)) begin
                state <= ACTIVE;
                p     <= 1'b1;
                cnt   <= w;
              end else cnt <= cnt - CNT_W'(1);
            ACTIVE:
              if (cnt == CNT_W'(1)) begin
                p     <= 1'b0;
                state <= last ? IDLE : GAP;
                d     <= last;
                cnt   <= g;
                rem   <= rem == '0 ? rem : rem - REP_W'(1);
              end else cnt <= cnt - CNT_W'(1);
            GAP:
              if (cnt == CNT_W'(1)) begin
                state <= ACTIVE;
                p     <= 1'b1;
                cnt   <= w;
              end else cnt <= cnt - CNT_W'(1);
            default: state <= IDLE;
          endcase
      end
    assign busy[i]      = state != IDLE;
    assign pulse_out[i] = p;
    assign done[i]      = d;
  end
endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb_multi_pulse_gen: directed scenarios plus random traffic, checked every cycle against a
// closed-form burst schedule (rise times, fall time, abort edge) per channel.
module tb_multi_pulse_gen;
  localparam int CH = 4, CW = 16, RW = 8, RD = 10;
  logic clk = 1'b0, reset = 1'b1;
  logic [CH-1:0] start = '0, abort = '0;
  logic [CW-1:0] cfg_delay = '0, cfg_width = '0, cfg_gap = '0;
  logic [RW-1:0] cfg_repeat = '0;
  logic ready;
  logic [CH-1:0] busy, pulse_out, done;
  multi_pulse_gen #(.CHANNELS(CH), .CNT_W(CW), .REP_W(RW), .RESET_DELAY(RD)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_repeat(cfg_repeat),
    .ready(ready), .busy(busy), .pulse_out(pulse_out), .done(done)
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_pass = 0;
  longint cyc = 0;
  int since = 0;
  bit mready = 1'b0;
  bit valid[CH], aborted[CH], cont[CH];
  longint e0[CH], a_edge[CH];
  int dd[CH], ww[CH], gg[CH], rr[CH];
  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, cyc);
  endtask
  function automatic longint fin(int c);
    return e0[c] + dd[c] + longint'(rr[c]) * (ww[c] + gg[c]) + ww[c];
  endfunction
  function automatic longint end_edge(int c);
    return aborted[c] ? a_edge[c] : cont[c] ? 64'h7fff_ffff_ffff : fin(c);
  endfunction
  function automatic bit exp_busy(int c, longint n);
    return valid[c] && n >= e0[c] && n < end_edge(c);
  endfunction
  function automatic bit exp_pulse(int c, longint n);
    longint off = n - (e0[c] + dd[c]);
    longint per = ww[c] + gg[c];
    return exp_busy(c, n) && off >= 0 && (off % per) < ww[c] && (cont[c] || off / per <= rr[c]);
  endfunction
  function automatic bit exp_done(int c, longint n);
    return valid[c] && !aborted[c] && !cont[c] && n == fin(c);
  endfunction
  task automatic step(input logic [CH-1:0] st, input logic [CH-1:0] ab, input int d, input int w, input int g, input int r);
    bit rb, bb;
    start = st;
    abort = ab;
    cfg_delay = CW'(d);
    cfg_width = CW'(w);
    cfg_gap = CW'(g);
    cfg_repeat = RW'(r);
    @(posedge clk);
    cyc++;
    rb = mready;
    since++;
    mready = since >= RD;
    for (int c = 0; c < CH; c++) begin
      bb = exp_busy(c, cyc - 1);
      if (bb && ab[c]) begin
        aborted[c] = 1'b1;
        a_edge[c] = cyc;
      end else if (!bb && rb && st[c] && !ab[c]) begin
        valid[c] = 1'b1;
        aborted[c] = 1'b0;
        e0[c] = cyc;
        dd[c] = d == 0 ? 1 : d;
        ww[c] = w == 0 ? 1 : w;
        gg[c] = g == 0 ? 1 : g;
        rr[c] = r;
`ifdef PULSE_GEN_CONTINUOUS_EN
        cont[c] = r == (1 << RW) - 1;
`else
        cont[c] = 1'b0;
`endif
      end
    end
    #1;
    check("ready", ready, mready);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("busy%0d", c), busy[c], exp_busy(c, cyc));
      check($sformatf("pulse%0d", c), pulse_out[c], exp_pulse(c, cyc));
      check($sformatf("done%0d", c), done[c], exp_done(c, cyc));
    end
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    start = '0;
    abort = '0;
    #1;
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", pulse_out, 0);
    check("rst_done", done, 0);
    for (int c = 0; c < CH; c++) valid[c] = 1'b0;
    since = 0;
    mready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1 reset = 1'b1;
  endtask
  initial begin
    #2 do_reset();
    idle(4);
    step('1, '0, 3, 4, 2, 2);
    idle(7);
    step(4'b0001, '0, 3, 4, 2, 2);
    idle(22);
    step(4'b0010, '0, 0, 0, 0, 1);
    idle(6);
    step(4'b0011, '0, 2, 6, 3, 1);
    idle(4);
    step(4'b0100, 4'b0101, 1, 1, 1, 0);
    idle(30);
    step('1, '0, 1, 2, 6, 3);
    idle(5);
    do_reset();
    idle(12);
    step(4'b0001, '0, 3, 4, 2, 2);
    idle(22);
    step(4'b1000, '0, 1, 2, 3, 255);
    idle(1300);
    step('0, 4'b1000, 0, 0, 0, 0);
    idle(10);
    for (int k = 0; k < 3000; k++) begin
      logic [CH-1:0] st, ab;
      for (int c = 0; c < CH; c++) begin
        st[c] = $urandom_range(3) == 0;
        ab[c] = $urandom_range(49) == 0;
      end
      step(st, ab, $urandom_range(5), $urandom_range(4), $urandom_range(4), $urandom_range(3));
    end
    idle(40);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
